// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer
//
// Multi-cycle controller in front of a shared N-bit adder. It accepts one
// operation at a time and steps it through the adder. ADD and SUB each take
// one adder pass. MUL takes N shift-add passes through the same adder. The
// N-bit result goes back over a valid/ready response channel.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   req_valid / req_ready  request handshake (req_ready high only in IDLE)
//   req_op, req_a, req_b   opcode (000 ADD, 001 SUB, 010 MUL) and operands
//   rsp_valid / rsp_ready  response handshake
//   rsp_result, rsp_err    result modulo 2^N, illegal-opcode flag
//   adder_a, adder_b       operands driven to the shared adder
//   adder_ctrl             adder function (000 add, 001 subtract)
//   adder_sum              combinational adder result, used in the same cycle
// ---------------------------------------------------------------------------
module alu_op_sequencer #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [2:0]   req_op,
    input  logic [N-1:0] req_a,
    input  logic [N-1:0] req_b,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_result,
    output logic         rsp_err,
    output logic [N-1:0] adder_a,
    output logic [N-1:0] adder_b,
    output logic [2:0]   adder_ctrl,
    input  logic [N-1:0] adder_sum
);

    localparam int STEP_W = $clog2(N + 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_MUL,
        ST_DONE
    } state_t;

    state_t            state_reg;
    logic [N-1:0]      mcand_reg;
    logic [N-1:0]      mplier_reg;
    logic [STEP_W-1:0] step_reg;

    logic [N-1:0] mcand_next;
    logic [N-1:0] mplier_next;

    assign mcand_next  = mcand_reg << 1;
    assign mplier_next = mplier_reg >> 1;

    // Combinational from the state register, so it also reads 1 during reset.
    assign req_ready = (state_reg == ST_IDLE);

    // The adder port is registered. It is loaded one edge ahead with the
    // operands for the coming cycle. During MUL, adder_a also serves as the
    // running accumulator, so no separate acc register is needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            step_reg   <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
            adder_a    <= '0;
            adder_b    <= '0;
            adder_ctrl <= OP_ADD;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (req_op == OP_ADD || req_op == OP_SUB) begin
                            adder_a    <= req_a;
                            adder_b    <= req_b;
                            adder_ctrl <= req_op;
                            state_reg  <= ST_EXEC;
                        end else if (req_op == OP_MUL) begin
                            mcand_reg  <= req_a;
                            mplier_reg <= req_b;
                            step_reg   <= '0;
                            adder_a    <= '0;
                            adder_b    <= req_b[0] ? req_a : '0;
                            adder_ctrl <= OP_ADD;
                            state_reg  <= ST_MUL;
                        end else begin
                            rsp_result <= '0;
                            rsp_err    <= 1'b1;
                            rsp_valid  <= 1'b1;
                            state_reg  <= ST_DONE;
                        end
                    end
                end

                ST_EXEC: begin
                    rsp_result <= adder_sum;
                    rsp_err    <= 1'b0;
                    rsp_valid  <= 1'b1;
                    adder_a    <= '0;
                    adder_b    <= '0;
                    adder_ctrl <= OP_ADD;
                    state_reg  <= ST_DONE;
                end

                ST_MUL: begin
                    if (step_reg == LAST_STEP) begin
                        rsp_result <= adder_sum;
                        rsp_err    <= 1'b0;
                        rsp_valid  <= 1'b1;
                        adder_a    <= '0;
                        adder_b    <= '0;
                        state_reg  <= ST_DONE;
                    end else begin
                        // The next partial product uses the shifted
                        // multiplicand and the next multiplier bit. A zero
                        // bit still spends an adder pass (adds 0), so MUL
                        // latency does not depend on the data.
                        adder_a    <= adder_sum;
                        adder_b    <= mplier_next[0] ? mcand_next : '0;
                        mcand_reg  <= mcand_next;
                        mplier_reg <= mplier_next;
                        step_reg   <= step_reg + 1'b1;
                    end
                    adder_ctrl <= OP_ADD;
                end

                ST_DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [2:0]   req_op;
    logic [N-1:0] req_a;
    logic [N-1:0] req_b;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [N-1:0] rsp_result;
    logic         rsp_err;
    logic [N-1:0] adder_a;
    logic [N-1:0] adder_b;
    logic [2:0]   adder_ctrl;
    logic [N-1:0] adder_sum;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Shared adder datapath seen by the sequencer.
    assign adder_sum = (adder_ctrl == 3'b001) ? (adder_a - adder_b) : (adder_a + adder_b);

    alu_op_sequencer #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .adder_a    (adder_a),
        .adder_b    (adder_b),
        .adder_ctrl (adder_ctrl),
        .adder_sum  (adder_sum)
    );

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_res;
        logic       exp_err;
        int         exp_lat;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: results from plain integer arithmetic reduced mod 2^N.
    function automatic void model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] res, output logic err, output int lat);
        int unsigned ia;
        int unsigned ib;
        int unsigned r;
        ia = a;
        ib = b;
        err = 1'b0;
        case (op)
            3'd0: begin r = (ia + ib) % 256; lat = 2; end
            3'd1: begin r = (ia + 256 - ib) % 256; lat = 2; end
            3'd2: begin r = (ia * ib) % 256; lat = N + 1; end
            default: begin r = 0; err = 1'b1; lat = 1; end
        endcase
        res = r[7:0];
    endfunction

    // One full transaction: request handshake, latency count, result check,
    // then an immediate response handshake.
    task automatic do_txn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] exp_res, input logic exp_err, input int exp_lat,
                          input string tag);
        int   lat;
        logic bad_ctrl;
        logic bad_ready;
        check({tag, " req_ready before"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_a     = 8'($urandom);
        req_b     = 8'($urandom);
        req_op    = 3'($urandom_range(0, 7));
        lat       = 1;
        bad_ctrl  = 1'b0;
        bad_ready = 1'b0;
        while (rsp_valid !== 1'b1 && lat < 64) begin
            if (lat == 1 && (op == 3'd0 || op == 3'd1)) begin
                check({tag, " exec adder_a"}, 32'(adder_a), 32'(a));
                check({tag, " exec adder_b"}, 32'(adder_b), 32'(b));
                check({tag, " exec adder_ctrl"}, 32'(adder_ctrl), 32'(op));
            end
            if (op == 3'd2 && adder_ctrl !== 3'b000) bad_ctrl = 1'b1;
            if (req_ready !== 1'b0) bad_ready = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " result"}, 32'(rsp_result), 32'(exp_res));
        check({tag, " err"}, 32'(rsp_err), 32'(exp_err));
        check({tag, " busy ctrl/ready"}, {30'd0, bad_ctrl, bad_ready}, 32'd0);
        check({tag, " done adder quiet"}, {13'd0, adder_a, adder_b, adder_ctrl}, 32'd0);
        $display("[TB] txn %s op=%0d a=%02h b=%02h -> result=%02h err=%0d lat=%0d",
                 tag, op, a, b, rsp_result, rsp_err, lat);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check({tag, " rsp_valid after hs"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] m_res;
        logic       m_err;
        int         m_lat;
        logic [2:0] r_op;
        logic [7:0] r_a;
        logic [7:0] r_b;
        logic       bad;
        int         lat;

        vecs[0] = '{3'b000, 8'h7F, 8'h01, 8'h80, 1'b0, 2};
        vecs[1] = '{3'b001, 8'h05, 8'h07, 8'hFE, 1'b0, 2};
        vecs[2] = '{3'b001, 8'h10, 8'h10, 8'h00, 1'b0, 2};
        vecs[3] = '{3'b010, 8'h0D, 8'h0B, 8'h8F, 1'b0, 9};
        vecs[4] = '{3'b010, 8'h10, 8'h20, 8'h00, 1'b0, 9};
        vecs[5] = '{3'b010, 8'hFF, 8'hFF, 8'h01, 1'b0, 9};
        vecs[6] = '{3'b111, 8'h12, 8'h34, 8'h00, 1'b1, 1};
        vecs[7] = '{3'b000, 8'hFF, 8'h02, 8'h01, 1'b0, 2};
        vecs[8] = '{3'b011, 8'hAA, 8'h55, 8'h00, 1'b1, 1};

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = 3'b000;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("reset req_ready", 32'(req_ready), 32'd1);
        check("reset rsp", {22'd0, rsp_valid, rsp_err, rsp_result}, 32'd0);
        check("reset adder", {13'd0, adder_a, adder_b, adder_ctrl}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle rsp_valid", 32'(rsp_valid), 32'd0);

        // Directed table.
        for (int i = 0; i < 9; i++) begin
            do_txn(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_res, vecs[i].exp_err,
                   vecs[i].exp_lat, $sformatf("vec%0d", i));
        end

        // Backpressure: hold rsp_ready low while presenting a new request.
        req_valid = 1'b1;
        req_op    = 3'b000;
        req_a     = 8'h11;
        req_b     = 8'h22;
        @(posedge clk); #1;
        req_op = 3'b010;
        req_a  = 8'h03;
        req_b  = 8'h04;
        @(posedge clk); #1;
        check("bp first result", {23'd0, rsp_valid, rsp_result}, {23'd0, 1'b1, 8'h33});
        bad = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_result !== 8'h33 || rsp_err !== 1'b0)
                bad = 1'b1;
        end
        check("bp held stable", 32'(bad), 32'd0);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("bp idle after hs", {30'd0, req_ready, rsp_valid}, 32'd2);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_a     = 8'hEE;
        req_b     = 8'hEE;
        check("bp second captured", 32'(req_ready), 32'd0);
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp mul latency", 32'(lat), 32'(N + 1));
        check("bp mul result", 32'(rsp_result), 32'h0C);
        $display("[TB] txn backpressure add 11+22 then mul 03*04 -> %02h lat=%0d", rsp_result, lat);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;

        // Reset during the 4th MUL cycle.
        req_valid = 1'b1;
        req_op    = 3'b010;
        req_a     = 8'h0D;
        req_b     = 8'h0B;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst req_ready", 32'(req_ready), 32'd1);
        check("midrst rsp", {22'd0, rsp_valid, rsp_err, rsp_result}, 32'd0);
        check("midrst adder", {13'd0, adder_a, adder_b, adder_ctrl}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bad = 1'b0;
        repeat (N + 2) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b0) bad = 1'b1;
        end
        check("midrst no response", 32'(bad), 32'd0);
        $display("[TB] txn reset mid-mul abandoned");
        do_txn(3'b000, 8'h02, 8'h03, 8'h05, 1'b0, 2, "post-reset add");

        // Random operations against the reference model.
        for (int i = 0; i < 30; i++) begin
            r_op = ($urandom_range(0, 9) < 9) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
            r_a  = 8'($urandom);
            r_b  = 8'($urandom);
            model(r_op, r_a, r_b, m_res, m_err, m_lat);
            do_txn(r_op, r_a, r_b, m_res, m_err, m_lat, $sformatf("rand%0d", i));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
